// File: rtl/alarm_pkg.sv
// Shared state encoding and field widths for the alarm clock core and its helpers.
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2
    } state_e;

    localparam int HH_W        = 5;
    localparam int MM_W        = 6;
    localparam int SS_W        = 6;
    localparam int SEC_PER_MIN = 60;

endpackage

// File: rtl/alarm_clock_core_sec_tick_gen.sv
// One-second divider: adv is the strobe at the wrapping edge, sec_tick its registered echo.
module sec_tick_gen #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    output logic adv,
    output logic sec_tick
);

    localparam int DIV_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_HZ - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             sec_tick_q, sec_tick_d;

    // A clear restarts the second and suppresses any advance due on the same edge.
    always_comb begin
        adv        = (div_q == DIV_LAST) && !clr;
        div_d      = div_q + DIV_W'(1);
        if (clr || (div_q == DIV_LAST)) begin
            div_d = '0;
        end
        sec_tick_d = adv;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            div_q      <= '0;
            sec_tick_q <= 1'b0;
        end else begin
            div_q      <= div_d;
            sec_tick_q <= sec_tick_d;
        end
    end

    assign sec_tick = sec_tick_q;

endmodule

// File: rtl/alarm_clock_core.sv
// Time-of-day counter, alarm registers and the ring/snooze/timeout state machine.
module alarm_clock_core
    import alarm_pkg::*;
#(
    parameter int CLK_HZ         = 100_000_000,
    parameter int SNOOZE_MIN     = 5,
    parameter int RING_TIMEOUT_S = 60,
    parameter int HOURS_MOD      = 24
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            set_time,
    input  logic            set_alarm,
    input  logic [HH_W-1:0] set_hh,
    input  logic [MM_W-1:0] set_mm,
    input  logic            alarm_en,
    input  logic            snooze_btn,
    input  logic            stop_btn,
    output logic [HH_W-1:0] hh,
    output logic [MM_W-1:0] mm,
    output logic [SS_W-1:0] ss,
    output logic            sec_tick,
    output logic            ringing,
    output logic            snoozing,
    output logic            flash,
    output logic            missed
);

    localparam int SNZ_LOAD = SNOOZE_MIN * SEC_PER_MIN;
    localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);
    localparam int RING_W   = $clog2(RING_TIMEOUT_S + 1);

    localparam logic [HH_W-1:0]   HH_LAST    = HH_W'(HOURS_MOD - 1);
    localparam logic [MM_W-1:0]   MM_LAST    = MM_W'(SEC_PER_MIN - 1);
    localparam logic [SS_W-1:0]   SS_LAST    = SS_W'(SEC_PER_MIN - 1);
    localparam logic [SNZ_W-1:0]  SNZ_INIT   = SNZ_W'(SNZ_LOAD);
    localparam logic [RING_W-1:0] RING_LIMIT = RING_W'(RING_TIMEOUT_S);

    logic [HH_W-1:0]   hh_q, hh_d, inc_hh, al_hh_q, al_hh_d;
    logic [MM_W-1:0]   mm_q, mm_d, inc_mm, al_mm_q, al_mm_d;
    logic [SS_W-1:0]   ss_q, ss_d, inc_ss;
    state_e            state_q, state_d;
    logic [RING_W-1:0] ring_cnt_q, ring_cnt_d, ring_inc;
    logic [SNZ_W-1:0]  snz_cnt_q, snz_cnt_d, snz_dec;
    logic              flash_q, flash_d;
    logic              missed_q, missed_d;
    logic              ringing_q, ringing_d;
    logic              snoozing_q, snoozing_d;

    logic set_ok, load_time, load_alarm, adv, match, sec_tick_w;

    assign set_ok     = (set_hh <= HH_LAST) && (set_mm <= MM_LAST);
    assign load_time  = set_time && set_ok;
    assign load_alarm = set_alarm && set_ok;

    sec_tick_gen #(
        .CLK_HZ (CLK_HZ)
    ) u_sec_tick_gen (
        .clk      (clk),
        .reset    (reset),
        .clr      (load_time),
        .adv      (adv),
        .sec_tick (sec_tick_w)
    );

    // Full carry chain resolves in one edge; a valid load overrides the advance.
    always_comb begin
        inc_ss = ss_q + SS_W'(1);
        inc_mm = mm_q;
        inc_hh = hh_q;
        if (ss_q == SS_LAST) begin
            inc_ss = '0;
            if (mm_q == MM_LAST) begin
                inc_mm = '0;
                inc_hh = (hh_q == HH_LAST) ? '0 : hh_q + HH_W'(1);
            end else begin
                inc_mm = mm_q + MM_W'(1);
            end
        end

        hh_d = hh_q;
        mm_d = mm_q;
        ss_d = ss_q;
        if (load_time) begin
            hh_d = set_hh;
            mm_d = set_mm;
            ss_d = '0;
        end else if (adv) begin
            hh_d = inc_hh;
            mm_d = inc_mm;
            ss_d = inc_ss;
        end

        al_hh_d = load_alarm ? set_hh : al_hh_q;
        al_mm_d = load_alarm ? set_mm : al_mm_q;
    end

    // Only a real second advance can hit the alarm; loading the time never does.
    assign match = adv && alarm_en && (inc_ss == '0) &&
                   (inc_mm == al_mm_q) && (inc_hh == al_hh_q);

    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        snz_cnt_d  = snz_cnt_q;
        flash_d    = flash_q;
        missed_d   = missed_q;
        ring_inc   = ring_cnt_q + RING_W'(1);
        snz_dec    = snz_cnt_q - SNZ_W'(1);

        if (!alarm_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (stop_btn) begin
                        missed_d = 1'b0;
                    end
                    if (match) begin
                        state_d    = RING;
                        ring_cnt_d = '0;
                        flash_d    = 1'b0;
                    end
                end
                RING: begin
                    if (stop_btn) begin
                        state_d  = IDLE;
                        missed_d = 1'b0;
                    end else if (snooze_btn) begin
                        state_d   = SNOOZE;
                        snz_cnt_d = SNZ_INIT;
                    end else if (adv) begin
                        if (ring_inc == RING_LIMIT) begin
                            state_d  = IDLE;
                            missed_d = 1'b1;
                        end else begin
                            ring_cnt_d = ring_inc;
                            flash_d    = !flash_q;
                        end
                    end
                end
                SNOOZE: begin
                    if (stop_btn) begin
                        state_d = IDLE;
                    end else if (adv) begin
                        snz_cnt_d = snz_dec;
                        if (snz_dec == '0) begin
                            state_d    = RING;
                            ring_cnt_d = '0;
                            flash_d    = 1'b0;
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end

        if (state_d != RING) begin
            flash_d = 1'b0;
        end
        ringing_d  = (state_d == RING);
        snoozing_d = (state_d == SNOOZE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hh_q       <= '0;
            mm_q       <= '0;
            ss_q       <= '0;
            al_hh_q    <= '0;
            al_mm_q    <= '0;
            state_q    <= IDLE;
            ring_cnt_q <= '0;
            snz_cnt_q  <= '0;
            flash_q    <= 1'b0;
            missed_q   <= 1'b0;
            ringing_q  <= 1'b0;
            snoozing_q <= 1'b0;
        end else begin
            hh_q       <= hh_d;
            mm_q       <= mm_d;
            ss_q       <= ss_d;
            al_hh_q    <= al_hh_d;
            al_mm_q    <= al_mm_d;
            state_q    <= state_d;
            ring_cnt_q <= ring_cnt_d;
            snz_cnt_q  <= snz_cnt_d;
            flash_q    <= flash_d;
            missed_q   <= missed_d;
            ringing_q  <= ringing_d;
            snoozing_q <= snoozing_d;
        end
    end

    assign hh       = hh_q;
    assign mm       = mm_q;
    assign ss       = ss_q;
    assign sec_tick = sec_tick_w;
    assign ringing  = ringing_q;
    assign snoozing = snoozing_q;
    assign flash    = flash_q;
    assign missed   = missed_q;

endmodule

// File: doc/alarm_clock_core.md
Name: alarm_clock_core

Overview:
Parametrised time-of-day and alarm engine for the board alarm clock. It keeps HH:MM:SS in binary from the system clock and compares the time against a programmable alarm. A ring/snooze/timeout state machine produces `ringing` (drives the song player's play input) and `flash` (display blink). The display mux consumes `hh`/`mm`/`ss` and performs its own /10 and %10 split.

Parameters:
- CLK_HZ, 100_000_000, clk cycles per second (must be ≥2).
- SNOOZE_MIN, 5, snooze length in minutes (1..60).
- RING_TIMEOUT_S, 60, seconds of unanswered ringing before auto-off (1..3600).
- HOURS_MOD, 24, hour wrap value (12 or 24; hours count 0..HOURS_MOD-1).

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- set_time  in  1  one-cycle pulse: load set_hh:set_mm:00 into time.
- set_alarm  in  1  one-cycle pulse: load set_hh:set_mm into alarm.
- set_hh  in  5  hour value for set pulses.
- set_mm  in  6  minute value for set pulses.
- alarm_en  in  1  level: alarm armed.
- snooze_btn  in  1  one-cycle pulse (debounced upstream).
- stop_btn  in  1  one-cycle pulse (debounced upstream).
- hh  out  5  current hour.
- mm  out  6  current minute.
- ss  out  6  current second.
- sec_tick  out  1  one-cycle pulse, cycle after each second advance.
- ringing  out  1  alarm sounding.
- snoozing  out  1  snooze countdown active.
- flash  out  1  toggles each second while ringing, else 0.
- missed  out  1  sticky: ring timed out unanswered.

Behaviour:
- Reset (async, immediate): all outputs 0, time 00:00:00, alarm 00:00, divider 0, state IDLE.
- Divider counts 0..CLK_HZ-1. At the edge where it equals CLK_HZ-1, it wraps to 0 and time advances one second. `sec_tick` is registered high for exactly the following cycle.
- Time advance: ss 59→0 carries to mm; mm 59→0 carries to hh; hh HOURS_MOD-1→0. All carries resolve in the same edge.
- set_time: if set_hh<HOURS_MOD and set_mm<60, load time to set_hh:set_mm:00 and clear the divider. Otherwise drop the pulse silently. set_time beats a coincident second advance; no tick is issued that cycle.
- set_alarm: same validity rule; loads alarm only. It never triggers a ring by itself.
- Match is evaluated only on a second advance. The condition is next time == alarm:00 and alarm_en=1. Loading time equal to alarm does not ring.
- FSM states IDLE, RING, SNOOZE (encoding from package):
  - IDLE→RING on match, at the same edge as the time update. ring_cnt is cleared and flash is set to 0.
  - RING: flash toggles and ring_cnt increments on each second advance.
  - RING→IDLE on stop_btn. Also clears missed.
  - RING→SNOOZE on snooze_btn. Loads snz_cnt with SNOOZE_MIN*60.
  - RING→IDLE when ring_cnt reaches RING_TIMEOUT_S at a second advance. Sets missed=1.
  - SNOOZE: snz_cnt decrements on each second advance. On reaching 0 it goes to RING, with ring_cnt cleared and flash 0.
  - SNOOZE→IDLE on stop_btn.
  - Any state→IDLE when alarm_en=0. This has priority over all other transitions; missed is unchanged.
  - Priority in one cycle: alarm_en=0 > stop_btn > snooze_btn > timeout/snooze expiry > match.
  - Buttons in IDLE are ignored, except that stop_btn clears missed.
  - A match while in RING or SNOOZE is ignored.
- Outputs:
  - ringing = (state==RING).
  - snoozing = (state==SNOOZE).
  - flash is forced 0 outside RING.
  - All outputs are registered.
- set_time/set_alarm during RING or SNOOZE update registers; state is unaffected.
- Counter widths:
  - snz_cnt width = clog2(SNOOZE_MIN*60+1).
  - ring_cnt width = clog2(RING_TIMEOUT_S+1).
  - divider width = clog2(CLK_HZ).
  - No arithmetic overflow is allowed.

Decomposition:
- Package alarm_pkg:
  - state enum (IDLE=0, RING=1, SNOOZE=2).
  - HH_W=5, MM_W=6, SS_W=6.
  - SEC_PER_MIN=60.
- One sub-module, sec_tick_gen (CLK_HZ parameter):
  - Inputs: clk, reset, clr.
  - Outputs: adv (edge-aligned advance strobe) and sec_tick (registered).
- Time counter, alarm registers and FSM stay in alarm_clock_core.

Test Plan:
- CLK_HZ=4. Release reset, run 4 clk → ss=1 and sec_tick high 1 cycle. Then set_time 23:59 and run 240 clk → 00:00:00 (HOURS_MOD=24); with HOURS_MOD=12, set_time 11:59 and run 240 clk → 00:00:00.
- CLK_HZ=4, alarm_en=1, set_alarm 00:01, set_time 00:00. After 60 ticks → ringing=1 at 00:01:00 and flash toggles 1,0,1 on the next ticks. A following set_time 00:01 does not re-ring.
- SNOOZE_MIN=1: snooze_btn during RING → ringing=0, snoozing=1. After exactly 60 ticks → ringing=1, snoozing=0.
- stop_btn and snooze_btn in the same cycle during RING → IDLE, snoozing stays 0. Dropping alarm_en during SNOOZE → IDLE next edge.
- RING_TIMEOUT_S=10: no buttons → ringing drops at the 10th tick and missed=1. A later stop_btn in IDLE → missed=0.
- set_time 24:00 or 12:60 → time unchanged. Asserting reset mid-clock-cycle while ringing → all outputs 0 immediately, before the next clk edge.
